// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared opcode and state enums for the counter command sequencer
package counter_seq_pkg;

  // Command opcodes as carried on cmd_op
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

endpackage

// File: rtl/counter_ref_model.sv
// rtl/counter_ref_model.sv - shadow up/down counter and sticky compare against the downstream counter
module counter_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  input  logic             check_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_exp;
  logic             r_mismatch;
  logic             w_miss;

  // The downstream counter moves every cycle, so the shadow does too; wrap is natural modulo 2^WIDTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp <= '0;
    end else if (load) begin
      r_exp <= data_in;
    end else if (up_down) begin
      r_exp <= r_exp + ONE;
    end else begin
      r_exp <= r_exp - ONE;
    end
  end

  assign w_miss = check_en && (data_out != r_exp);

  // Sticky mismatch; a fresh miss wins over a clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_miss | (r_mismatch & ~clr_err);
    end
  end

  assign exp_count = r_exp;
  assign mismatch  = r_mismatch;

endmodule

// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - command sequencer driving a downstream up/down counter with self-check
module counter_cmd_seq
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             load,
  output logic             up_down,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  input  logic             check_en,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             op_err,
  output logic [WIDTH-1:0] exp_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic             r_load, w_load_nxt;
  logic             r_up_down, w_up_down_nxt;
  logic [WIDTH-1:0] r_data_in, w_data_in_nxt;
  logic             r_done, w_done_nxt;
  logic             r_op_err, w_op_err_nxt;
  logic             r_busy, r_cmd_ready;
  logic [1:0]       r_rst_sync;
  logic             w_live;
  logic             w_accept;
  op_e              w_op;

  // Release of reset is retimed so commands are taken only once both stages have seen it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_live   = r_rst_sync[1];
  assign w_accept = cmd_valid && r_cmd_ready && w_live;
  assign w_op     = op_e'(cmd_op);

  // Next state and next registered outputs; everything holds unless a transition says otherwise
  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_load_nxt    = 1'b0;
    w_up_down_nxt = r_up_down;
    w_data_in_nxt = r_data_in;
    w_done_nxt    = 1'b0;
    w_op_err_nxt  = r_op_err & ~clr_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_LOAD: begin
              w_state_nxt   = ST_LOAD;
              w_load_nxt    = 1'b1;
              w_data_in_nxt = cmd_data;
            end
            OP_UP, OP_DOWN: begin
              w_state_nxt   = ST_RUN;
              w_up_down_nxt = (w_op == OP_UP);
              // r_rem counts the RUN cycles still to go after the current one; len 0 behaves as 1
              w_rem_nxt     = (cmd_len == '0) ? '0 : cmd_len - LEN_ONE;
            end
            default: begin
              w_op_err_nxt = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      ST_RUN: begin
        if (r_rem == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_rem_nxt = r_rem - LEN_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, length counter and every output are registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_load      <= 1'b0;
      r_up_down   <= 1'b1;
      r_data_in   <= '0;
      r_done      <= 1'b0;
      r_op_err    <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_load      <= w_load_nxt;
      r_up_down   <= w_up_down_nxt;
      r_data_in   <= w_data_in_nxt;
      r_done      <= w_done_nxt;
      r_op_err    <= w_op_err_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  counter_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .clk       (clk),
    .reset     (reset),
    .load      (r_load),
    .up_down   (r_up_down),
    .data_in   (r_data_in),
    .data_out  (data_out),
    .check_en  (check_en),
    .clr_err   (clr_err),
    .exp_count (exp_count),
    .mismatch  (mismatch)
  );

  assign cmd_ready = r_cmd_ready;
  assign load      = r_load;
  assign up_down   = r_up_down;
  assign data_in   = r_data_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// tb/tb_counter_cmd_seq.sv - directed scoreboard bench for counter_cmd_seq
module tb_counter_cmd_seq;

  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          load, up_down;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out = '0;
  logic          check_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          busy, done, mismatch, op_err;
  logic [W-1:0]  exp_count;

  always #5 clk = ~clk;

  counter_cmd_seq #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .load      (load),
    .up_down   (up_down),
    .data_in   (data_in),
    .data_out  (data_out),
    .check_en  (check_en),
    .clr_err   (clr_err),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .op_err    (op_err),
    .exp_count (exp_count)
  );

  typedef struct {
    string        tag;
    logic         ld;
    logic         ud;
    logic [W-1:0] din;
    logic         bsy;
    logic         dn;
    logic         rdy;
    logic         mm;
    logic         oe;
    logic         cx;
    logic [W-1:0] ex;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic push(input string tag, input logic ld, input logic ud, input logic [W-1:0] din,
                      input logic bsy, input logic dn, input logic rdy, input logic mm,
                      input logic oe, input logic cx, input logic [W-1:0] ex);
    exp_t e;
    e.tag = tag; e.ld = ld; e.ud = ud; e.din = din; e.bsy = bsy; e.dn = dn;
    e.rdy = rdy; e.mm = mm; e.oe = oe; e.cx = cx; e.ex = ex;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".load"},     32'(load),      32'(e.ld));
      chk({e.tag, ".up_down"},  32'(up_down),   32'(e.ud));
      chk({e.tag, ".data_in"},  32'(data_in),   32'(e.din));
      chk({e.tag, ".busy"},     32'(busy),      32'(e.bsy));
      chk({e.tag, ".done"},     32'(done),      32'(e.dn));
      chk({e.tag, ".cmd_ready"},32'(cmd_ready), 32'(e.rdy));
      chk({e.tag, ".mismatch"}, 32'(mismatch),  32'(e.mm));
      chk({e.tag, ".op_err"},   32'(op_err),    32'(e.oe));
      if (e.cx) chk({e.tag, ".exp_count"}, 32'(exp_count), 32'(e.ex));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] d, input logic [LW-1:0] len);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".load"},      32'(load),      32'(1'b0));
    chk({tag, ".up_down"},   32'(up_down),   32'(1'b1));
    chk({tag, ".data_in"},   32'(data_in),   32'(4'h0));
    chk({tag, ".busy"},      32'(busy),      32'(1'b0));
    chk({tag, ".done"},      32'(done),      32'(1'b0));
    chk({tag, ".mismatch"},  32'(mismatch),  32'(1'b0));
    chk({tag, ".op_err"},    32'(op_err),    32'(1'b0));
    chk({tag, ".exp_count"}, 32'(exp_count), 32'(4'h0));
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset held low
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // LOAD A
    drive(1'b1, 2'b00, 4'hA, 8'd0);
    push("ld_a1", 1, 1, 4'hA, 1, 0, 0, 0, 0, 0, 4'h0);
    tick();
    drive(1'b0, 2'b00, 4'h0, 8'd0);
    push("ld_a2", 0, 1, 4'hA, 0, 1, 1, 0, 0, 1, 4'hA);
    tick();

    // LOAD E accepted in the done cycle, then UP len 3 held through LOAD
    drive(1'b1, 2'b00, 4'hE, 8'd0);
    push("ld_e", 1, 1, 4'hE, 1, 0, 0, 0, 0, 0, 4'h0);
    tick();
    drive(1'b1, 2'b01, 4'h9, 8'd3);
    push("up_wait", 0, 1, 4'hE, 0, 1, 1, 0, 0, 1, 4'hE);
    tick();
    push("up_r1", 0, 1, 4'hE, 1, 0, 0, 0, 0, 1, 4'hF);
    tick();
    drive(1'b0, 2'b00, 4'h3, 8'd0);
    push("up_r2", 0, 1, 4'hE, 1, 0, 0, 0, 0, 1, 4'h0);
    tick();
    push("up_r3", 0, 1, 4'hE, 1, 0, 0, 0, 0, 1, 4'h1);
    tick();
    push("up_done", 0, 1, 4'hE, 0, 1, 1, 0, 0, 1, 4'h2);
    tick();

    // DOWN len 0, then a LOAD 5 held valid is taken in the done cycle
    drive(1'b1, 2'b10, 4'h9, 8'd0);
    push("dn_r1", 0, 0, 4'hE, 1, 0, 0, 0, 0, 1, 4'h3);
    tick();
    drive(1'b1, 2'b00, 4'h5, 8'd0);
    push("dn_done", 0, 0, 4'hE, 0, 1, 1, 0, 0, 1, 4'h2);
    tick();
    push("b2b_ld", 1, 0, 4'h5, 1, 0, 0, 0, 0, 1, 4'h1);
    tick();
    drive(1'b0, 2'b00, 4'h0, 8'd0);
    push("b2b_done", 0, 0, 4'h5, 0, 1, 1, 0, 0, 1, 4'h5);
    tick();

    // Mismatch set, clear colliding with a new miss, clear, then a matching compare
    check_en = 1'b1; data_out = 4'h4;
    push("mm_set", 0, 0, 4'h5, 0, 0, 1, 1, 0, 1, 4'h4);
    tick();
    data_out = 4'h5; clr_err = 1'b1;
    push("mm_clr_hit", 0, 0, 4'h5, 0, 0, 1, 1, 0, 1, 4'h3);
    tick();
    check_en = 1'b0;
    push("mm_clr", 0, 0, 4'h5, 0, 0, 1, 0, 0, 1, 4'h2);
    tick();
    clr_err = 1'b0; check_en = 1'b1; data_out = 4'h2;
    push("mm_match", 0, 0, 4'h5, 0, 0, 1, 0, 0, 1, 4'h1);
    tick();
    check_en = 1'b0;

    // Reserved op
    drive(1'b1, 2'b11, 4'h9, 8'd4);
    push("rsvd1", 0, 0, 4'h5, 0, 0, 1, 0, 1, 1, 4'h0);
    tick();
    drive(1'b0, 2'b00, 4'h0, 8'd0);
    push("rsvd2", 0, 0, 4'h5, 0, 0, 1, 0, 1, 1, 4'hF);
    tick();
    clr_err = 1'b1;
    push("rsvd_clr", 0, 0, 4'h5, 0, 0, 1, 0, 0, 1, 4'hE);
    tick();
    clr_err = 1'b0;

    // UP len 5 interrupted by reset in its second cycle
    drive(1'b1, 2'b01, 4'h7, 8'd5);
    push("ab_r1", 0, 1, 4'h5, 1, 0, 0, 0, 0, 1, 4'hD);
    tick();
    drive(1'b0, 2'b00, 4'h0, 8'd0);
    push("ab_r2", 0, 1, 4'h5, 1, 0, 0, 0, 0, 1, 4'hE);
    tick();
    reset = 1'b0;
    #1;
    chk_reset_vals("ab_rst");
    @(negedge clk);
    chk_reset_vals("ab_hold");
    reset = 1'b1;
    drive(1'b1, 2'b00, 4'h7, 8'd0);

    // No done from the abandoned run; first accept not before the second edge
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk("rel.busy_edge1", 32'(busy), 32'(1'b0));
      chk("rel.no_done", 32'(done), 32'(1'b0));
      if (load) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rel.load_seen", 32'(seen), 32'(1'b1));
    chk("rel.data_in", 32'(data_in), 32'(4'h7));
    drive(1'b0, 2'b00, 4'h0, 8'd0);
    push("rel_done", 0, 1, 4'h7, 0, 1, 1, 0, 0, 1, 4'h7);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter data width.
REQ-002 SHALL have parameter LEN_W, default 8, run-length field width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both valid and ready are high at a clk edge.
REQ-007 SHALL have port cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 reserved.
REQ-008 SHALL have port cmd_data  input  WIDTH  load value for LOAD.
REQ-009 SHALL have port cmd_len  input  LEN_W  run cycles for UP/DOWN; 0 is treated as 1.
REQ-010 SHALL have port load, up_down, data_in  output  1/1/WIDTH  drive the downstream up/down counter.
REQ-011 SHALL have port data_out  input  WIDTH  counter value returned from the downstream counter.
REQ-012 SHALL have port check_en, clr_err  input  1/1  compare enable; synchronous clear of sticky error.
REQ-013 SHALL have port busy, done, mismatch, op_err  output  1 each  status.
REQ-014 SHALL have port exp_count  output  WIDTH  expected counter value.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN; cmd_ready=1 only in IDLE; busy=1 in LOAD and RUN.
REQ-016 Accept of LOAD in IDLE SHALL enter LOAD the next cycle with load=1 and data_in=cmd_data for exactly one cycle, then return to IDLE.
REQ-017 Accept of UP/DOWN SHALL enter RUN with up_down=1/0 and load=0 for exactly max(cmd_len,1) consecutive cycles, then return to IDLE.
REQ-018 Accept of op 11 SHALL leave state IDLE, drive nothing, and set op_err sticky (cleared by clr_err).
REQ-019 done SHALL pulse one cycle in the first IDLE cycle after a LOAD or RUN completes; a new command MAY be accepted in that same cycle.
REQ-020 In IDLE, load SHALL be 0, up_down SHALL hold its last value, and data_in SHALL hold its last value.
REQ-021 All outputs SHALL be registered; command-to-first-drive latency SHALL be exactly 1 cycle.
REQ-022 exp_count SHALL update each cycle: data_in if load=1, else exp_count+1 if up_down=1, else exp_count-1, all modulo 2^WIDTH (F+1=0, 0-1=F).
REQ-023 When check_en=1, data_out!=exp_count at a clk edge SHALL set mismatch the following cycle; mismatch stays set until clr_err=1.
REQ-024 clr_err and a new mismatch in the same cycle SHALL leave mismatch set.
REQ-025 cmd_* inputs SHALL be ignored while cmd_ready=0; inputs captured at accept SHALL not be re-sampled.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, load=0, up_down=1, data_in=0, busy=0, done=0, mismatch=0, op_err=0, exp_count=0, remaining-length counter=0; cmd_ready=1.
REQ-027 Reset asserted mid-LOAD or mid-RUN SHALL abandon the command with no done pulse.
REQ-028 Reset deassertion SHALL be synchronised internally so the first accept occurs no earlier than the second clk edge after release.

Structure
REQ-029 Package counter_seq_pkg SHALL hold the op enum (OP_LOAD, OP_UP, OP_DOWN, OP_RSVD) and the state enum.
REQ-030 Sub-module counter_ref_model SHALL contain exp_count and the mismatch comparator; the FSM and length counter stay in counter_cmd_seq.

Verification
REQ-031 Reset: hold reset=0 -> all outputs at REQ-026 values, cmd_ready=1.
REQ-032 LOAD 4'hA accepted at edge t -> load=1, data_in=A in cycle t+1; done=1 and exp_count=A in cycle t+2.
REQ-033 After LOAD 4'hE, UP len=3 -> up_down=1 for 3 cycles, cmd_ready=0 throughout, exp_count E->F->0->1, one done pulse.
REQ-034 DOWN len=0 -> exactly one RUN cycle with up_down=0; a back-to-back command held valid is accepted in the done cycle.
REQ-035 check_en=1 with data_out forced to exp_count^1 -> mismatch=1 the next cycle, held until clr_err; op 11 -> op_err=1, busy stays 0.
REQ-036 reset=0 during cycle 2 of UP len=5 -> immediate IDLE, load=0, up_down=1, no done pulse after release.
